// File: rtl/mips_pkg.sv
// Shared encodings for the writeback path: source, destination,
// load size, FSM states and the request FIFO entry layout.
package mips_pkg;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_MEM  = 2'b01;
   localparam logic [1:0] SRC_LINK = 2'b10;
   localparam logic [1:0] SRC_HILO = 2'b11;

   localparam logic [1:0] DST_RD   = 2'b00;
   localparam logic [1:0] DST_RT   = 2'b01;
   localparam logic [1:0] DST_LINK = 2'b10;
   localparam logic [1:0] DST_RSVD = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FORMAT = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;

   // word holds the already-selected source operand
   typedef struct packed {
      logic        vld;
      logic        drop;
      logic [4:0]  dst;
      logic [1:0]  src;
      logic [31:0] word;
      logic [1:0]  size;
      logic        sgn;
      logic [1:0]  off;
   } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Little-endian load extraction with sign or zero extension.
// Purely combinational.
module load_formatter
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  off,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      unique case (size)
         SZ_BYTE: data = {{24{sgn & b[7]}}, b};
         SZ_HALF: data = {{16{sgn & h[15]}}, h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: request FIFO, destination resolution,
// load formatting and a three-state IDLE/FORMAT/WRITE sequencer.
module writeback_unit #(
   parameter int DEPTH    = 2,
   parameter int LINK_REG = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_src,
   input  logic [1:0]  req_dst_sel,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rt,
   input  logic [31:0] req_alu,
   input  logic [31:0] req_mem,
   input  logic [31:0] req_pc4,
   input  logic [31:0] req_hilo,
   input  logic [1:0]  req_ld_size,
   input  logic        req_ld_signed,
   input  logic [1:0]  req_ld_off,
   output logic        rf_wr_en,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic        wb_done,
   output logic [31:0] pending_mask,
   output logic        busy,
   output logic        err_dst
);

   import mips_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

   wb_entry_t       fifo_q [DEPTH];
   wb_entry_t       fifo_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      state_q, state_d;
   logic            wr_en_q, wr_en_d;
   logic            done_q, done_d;
   logic [4:0]      addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            err_q, err_d;
   logic [31:0]     pend;
   wb_entry_t       new_e;
   wb_entry_t       head;
   logic [31:0]     ld_data;
   logic            push, pop;

   assign req_ready = count_q < FULL;
   assign push      = req_valid && req_ready;
   assign pop       = state_q == ST_WRITE;
   assign head      = fifo_q[rd_ptr_q];

   load_formatter u_fmt (
      .word (head.word),
      .size (head.size),
      .sgn  (head.sgn),
      .off  (head.off),
      .data (ld_data)
   );

   always_comb begin
      new_e      = '0;
      new_e.vld  = 1'b1;
      new_e.src  = req_src;
      new_e.size = req_ld_size;
      new_e.sgn  = req_ld_signed;
      new_e.off  = req_ld_off;
      unique case (req_src)
         SRC_ALU:  new_e.word = req_alu;
         SRC_MEM:  new_e.word = req_mem;
         SRC_LINK: new_e.word = req_pc4;
         default:  new_e.word = req_hilo;
      endcase
      unique case (req_dst_sel)
         DST_RD:   new_e.dst  = req_rd;
         DST_RT:   new_e.dst  = req_rt;
         DST_LINK: new_e.dst  = LINK_IDX;
         default:  new_e.drop = 1'b1;
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      if (pop) begin
         fifo_d[rd_ptr_q].vld = 1'b0;
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
         fifo_d[wr_ptr_q] = new_e;
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (req_dst_sel == DST_RSVD) err_d = 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d = state_q;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE:
            if (count_q != '0) state_d = ST_FORMAT;
         ST_FORMAT: begin
            state_d = ST_WRITE;
            addr_d  = head.dst;
            data_d  = (head.src == SRC_MEM) ? ld_data : head.word;
            wr_en_d = !head.drop && (head.dst != 5'd0);
            done_d  = 1'b1;
         end
         ST_WRITE:
            state_d = (count_d != '0) ? ST_FORMAT : ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // the head stays queued until its WRITE, so it is still pending
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (fifo_q[i].vld && !fifo_q[i].drop)
            pend[fifo_q[i].dst] = 1'b1;
      pend[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         wr_en_q  <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         wr_en_q  <= wr_en_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   assign rf_wr_en     = wr_en_q;
   assign rf_wr_addr   = addr_q;
   assign rf_wr_data   = data_q;
   assign wb_done      = done_q;
   assign pending_mask = pend;
   assign busy         = (count_q != '0) || (state_q != ST_IDLE);
   assign err_dst      = err_q;

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of request FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter LINK_REG, default 31, meaning the destination register index used for link writes.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  writeback request present.
REQ-006 SHALL have port req_ready  out  1  request accepted at this edge if req_valid is also high.
REQ-007 SHALL have port req_src  in  2  data source: 00 ALU, 01 MEM, 10 LINK, 11 HILO.
REQ-008 SHALL have port req_dst_sel  in  2  destination select: 00 rd, 01 rt, 10 LINK_REG, 11 reserved.
REQ-009 SHALL have ports req_rd and req_rt  in  5 each  instruction register fields.
REQ-010 SHALL have ports req_alu, req_mem, req_pc4 and req_hilo  in  32 each  source data words.
REQ-011 SHALL have port req_ld_size  in  2  load size: 00 byte, 01 half, 10 or 11 word.
REQ-012 SHALL have port req_ld_signed  in  1  sign-extend loads.
REQ-013 SHALL have port req_ld_off  in  2  load byte offset.
REQ-014 SHALL have ports rf_wr_en  out  1, rf_wr_addr  out  5 and rf_wr_data  out  32  register file write port with the destination already resolved.
REQ-015 SHALL have port wb_done  out  1  one-cycle pulse per retired request.
REQ-016 SHALL have port pending_mask  out  32  registers with an outstanding write.
REQ-017 SHALL have port busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-018 SHALL have port err_dst  out  1  sticky flag for a reserved destination select.

Function
REQ-019 SHALL drive req_ready high exactly when the FIFO count is less than DEPTH, with no same-cycle pop bypass.
REQ-020 SHALL store each accepted request with its destination resolved at push: 00 gives rd, 01 gives rt, 10 gives LINK_REG, 11 gives a drop-marked entry.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH and SHALL handle a simultaneous push and pop without changing the count.
REQ-022 SHALL implement FSM IDLE -> FORMAT -> WRITE: IDLE goes to FORMAT when the FIFO is non-empty; FORMAT always goes to WRITE; WRITE pops the head and goes to FORMAT if another entry remains, otherwise to IDLE.
REQ-023 SHALL register the formatted data in FORMAT: ALU passes req_alu, LINK passes req_pc4, HILO passes req_hilo, MEM passes the formatted load value.
REQ-024 SHALL format loads little-endian: byte takes bits [8*off+7:8*off]; half takes bits [15:0] when off[1]=0, else [31:16]; both are sign- or zero-extended per ld_signed; word passes unchanged and ignores off.
REQ-025 SHALL assert rf_wr_en for exactly the WRITE cycle, with addr and data stable, except when the destination is 0 or the entry is drop-marked.
REQ-026 SHALL pulse wb_done in every WRITE cycle, including suppressed writes.
REQ-027 SHALL give a latency of two cycles from the acceptance edge to rf_wr_en high, and SHALL sustain a throughput of one write per two cycles.
REQ-028 SHALL set pending_mask bit n while any FIFO entry or in-flight entry targets n, SHALL keep bit 0 always 0, and SHALL clear a bit in the cycle after its last WRITE.
REQ-029 SHALL set err_dst when it accepts dst_sel=11 and SHALL clear it only by reset.
REQ-030 SHALL hold rf_wr_addr and rf_wr_data at their last values and rf_wr_en at 0 when not in WRITE.

Reset
REQ-031 SHALL on reset, asynchronously, put the FSM in IDLE, the FIFO empty with pointers at 0, and rf_wr_en, rf_wr_addr, rf_wr_data, wb_done, pending_mask, busy and err_dst at 0.
REQ-032 SHALL drive req_ready to 1 during and after reset.
REQ-033 SHALL discard an in-flight write on reset asserted mid-operation, with no rf_wr_en pulse.

Structure
REQ-034 SHALL place the source codes, destination-select codes, load-size codes and FSM state encoding in shared package mips_pkg.
REQ-035 SHALL implement load formatting as sub-module load_formatter, which is purely combinational with inputs word, size, signed and off.

Verification
REQ-036 SHALL cover ALU writeback: src=00, dst_sel=00, rd=8, alu=0x12345678 -> two cycles later rf_wr_en=1, addr=8, data=0x12345678, wb_done=1, pending_mask bit 8 set then cleared.
REQ-037 SHALL cover a signed byte load: src=01, mem=0x80FF7F01, size=00, off=2, signed=1, dst_sel=01, rt=9 -> data=0xFFFFFFFF; the same request with signed=0 -> data=0x000000FF.
REQ-038 SHALL cover a link write: src=10, dst_sel=10, pc4=0x00400010 -> addr=31, data=0x00400010.
REQ-039 SHALL cover the zero destination: dst_sel=00, rd=0 -> wb_done=1, rf_wr_en=0, pending_mask bit 0 never set.
REQ-040 SHALL cover back-pressure: three back-to-back requests with DEPTH=2 -> req_ready=0 after two accepts, the third accepted after the first WRITE, three writes in order spaced two cycles apart.
REQ-041 SHALL cover reset mid-operation: reset asserted during FORMAT -> no rf_wr_en, busy=0, pending_mask=0, and a subsequent request completes normally.
